mux_rr: RTL and testbench
=========================

MUX_RR -- requirements
Module: mux_rr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data bits per channel.
REQ-002 The module SHALL have parameter CHANNELS, default 8, meaning the input channel count (legal values 2..16).
REQ-003 The module SHALL have parameter SELW, default $clog2(CHANNELS), meaning the channel-index width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port mode, input, 1 bit: 0 selects manual mode, 1 selects round-robin mode.
REQ-007 Port sel, input, SELW bits: the manual-mode channel index.
REQ-008 Port din, input, CHANNELS*WIDTH bits: channel k data occupies din[k*WIDTH +: WIDTH].
REQ-009 Port req, input, CHANNELS bits: per-channel data-valid request.
REQ-010 Port gnt, output, CHANNELS bits: one-hot combinational grant, high in the cycle channel k is captured.
REQ-011 Port q, output, WIDTH bits: registered selected data.
REQ-012 Port q_ch, output, SELW bits: registered index of the channel held in q.
REQ-013 Port q_valid, output, 1 bit: q and q_ch hold an unconsumed word.
REQ-014 Port q_ready, input, 1 bit: the downstream accepts q in a cycle where q_valid && q_ready.

Function
REQ-015 The output register SHALL be able to load when (!q_valid || q_ready).
REQ-016 In manual mode, the candidate SHALL be channel sel if sel < CHANNELS and req[sel]=1; otherwise there SHALL be no candidate.
REQ-017 In round-robin mode, the candidate SHALL be the first k with req[k]=1, searching ptr+1, ptr+2, ... modulo CHANNELS and ending with ptr itself.
REQ-018 A capture SHALL occur when the register can load and a candidate exists; in that cycle gnt[candidate]=1, all other gnt bits SHALL be 0, and on the next edge q<=din[candidate], q_ch<=candidate, q_valid<=1, ptr<=candidate.
REQ-019 gnt SHALL be all-zero whenever no capture occurs, including when q_valid=1 and q_ready=0.
REQ-020 The latency from a request seen at a capture edge to q_valid=1 SHALL be exactly 1 cycle.
REQ-021 If q_valid=1, q_ready=1 and no capture occurs, q_valid SHALL clear on the next edge; q and q_ch SHALL hold their values.
REQ-022 Simultaneous consume and capture SHALL replace the word with q_valid staying 1, giving a throughput of one word per cycle.
REQ-023 While q_valid=1 and q_ready=0, q, q_ch and q_valid SHALL be held stable regardless of din, req, sel or mode.
REQ-024 Manual captures SHALL also update ptr, so that a later switch to round-robin starts after the last granted channel.
REQ-025 A change of mode or sel SHALL take effect on the same-cycle candidate evaluation and SHALL NOT disturb a held word.
REQ-026 With a single requester, round-robin mode SHALL grant that requester every loadable cycle, including when it equals ptr.
REQ-027 ptr SHALL wrap from CHANNELS-1 to 0, including for non-power-of-two CHANNELS; indices >= CHANNELS SHALL never be granted.

Reset
REQ-028 While rst_n=0, the module SHALL force q=0, q_ch=0, q_valid=0 and ptr=CHANNELS-1, independent of clk.
REQ-029 While rst_n=0, gnt SHALL be 0.
REQ-030 Assertion of reset mid-transfer SHALL discard the held word; the first round-robin grant after reset SHALL be to the lowest requesting index.
REQ-031 Reset release SHALL be synchronised by the integrator; the first capture SHALL occur at the first rising edge with rst_n=1.

Verification (WIDTH=8, CHANNELS=8 unless noted)
REQ-032 Manual mode, sel=3, req=8'h08, din ch3=8'hA5, q_ready=1 -> gnt=8'h08 in that cycle; next cycle q=8'hA5, q_ch=3, q_valid=1.
REQ-033 Round-robin mode, req=8'hFF held, q_ready=1 -> grants 0,1,2,...,7,0 on consecutive cycles with no bubbles.
REQ-034 Round-robin mode, req=8'h24, q_ready=0 after the first capture -> q_ch=2 held, gnt=0 for 5 cycles; on q_ready=1, the next grant is ch5 and then ch2.
REQ-035 Manual mode, sel=6, req[6]=0 -> no grant and q_valid deasserts after consume; sel=7 with CHANNELS=6 -> never granted.
REQ-036 Manual capture of ch4, then switch to round-robin with req=8'h31 -> the next grant is ch5.
REQ-037 rst_n pulled low mid-stream with q_valid=1 -> q=0, q_valid=0, gnt=0 immediately (asynchronous); after release with req=8'hC2, the first grant is ch1.

Source files
------------

// File: rtl/mux_rr.sv
// mux_rr: N-channel data multiplexer with manual or round-robin selection
// into a single registered output word with valid/ready handshake.
module mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       req,
    output logic [CHANNELS-1:0]       gnt,
    output logic [WIDTH-1:0]          q,
    output logic [SELW-1:0]           q_ch,
    output logic                      q_valid,
    input  logic                      q_ready
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_q;
    logic [SELW-1:0]  r_q_ch;
    logic             r_q_valid;

    logic             w_man_hit;
    logic             w_rr_hit;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_hit;
    logic [SELW-1:0]  w_cand;
    logic             w_load;
    logic             w_cap;
    logic [WIDTH-1:0] w_data;

    // Round-robin search: scan from ptr+1 upward, ptr itself checked last.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            v_idx = (int'(r_ptr) + i) % CHANNELS;
            if (req[SELW'(v_idx)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = SELW'(v_idx);
            end
        end
    end

    // Candidate selection, capture decision and one-hot grant.
    always_comb begin
        w_man_hit = (int'(sel) < CHANNELS) && req[sel];
        w_hit     = mode ? w_rr_hit : w_man_hit;
        w_cand    = mode ? w_rr_idx : sel;
        w_load    = !r_q_valid || q_ready;
        w_cap     = rst_n && w_load && w_hit;
        w_data    = din[w_cand*WIDTH +: WIDTH];
        gnt       = w_cap ? (CHANNELS'(1) << w_cand) : '0;
    end

    // Output word register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_q_ch    <= '0;
            r_q_valid <= 1'b0;
            r_ptr     <= SELW'(CHANNELS - 1);
        end else if (w_cap) begin
            r_q       <= w_data;
            r_q_ch    <= w_cand;
            r_q_valid <= 1'b1;
            r_ptr     <= w_cand;
        end else if (q_ready) begin
            r_q_valid <= 1'b0;
        end
    end

    assign q       = r_q;
    assign q_ch    = r_q_ch;
    assign q_valid = r_q_valid;

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: directed bench for mux_rr with an expected-word scoreboard.
// A second 6-channel instance covers out-of-range select and pointer wrap.
module tb_mux_rr;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic [63:0] din;
    logic [7:0]  req;
    logic [7:0]  gnt;
    logic [7:0]  q;
    logic [2:0]  q_ch;
    logic        q_valid;
    logic        q_ready;

    logic [47:0] din6;
    logic [5:0]  req6;
    logic [5:0]  gnt6;
    logic [7:0]  q6;
    logic [2:0]  q_ch6;
    logic        q_valid6;

    logic [7:0]  d [8];
    exp_t        sb [$];
    int          n_cmp;
    int          n_err;

    mux_rr #(.WIDTH(8), .CHANNELS(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .din(din), .req(req), .gnt(gnt), .q(q), .q_ch(q_ch),
        .q_valid(q_valid), .q_ready(q_ready)
    );

    mux_rr #(.WIDTH(8), .CHANNELS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .din(din6), .req(req6), .gnt(gnt6), .q(q6), .q_ch(q_ch6),
        .q_valid(q_valid6), .q_ready(q_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grant before the edge, then the word after it.
    task automatic cyc(input string tag, input int exp_ch, input logic exp_v);
        exp_t e;
        logic [7:0] g;
        @(negedge clk);
        g = (exp_ch < 0) ? 8'h00 : (8'h01 << exp_ch);
        chk({tag, " gnt"}, 32'(gnt), 32'(g));
        if (exp_ch >= 0) begin
            e.ch  = 3'(exp_ch);
            e.dat = d[exp_ch];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, " q_valid"}, 32'(q_valid), 32'(exp_v));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " q_ch"}, 32'(q_ch), 32'(e.ch));
            chk({tag, " q"}, 32'(q), 32'(e.dat));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 8; k++) d[k] = 8'(8'h11 * (k + 1));
        d[3] = 8'hA5;
        for (int k = 0; k < 8; k++) din[k*8 +: 8] = d[k];
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'hC0 + k);
        rst_n   = 1'b0;
        mode    = 1'b1;
        sel     = 3'd0;
        req     = 8'hFF;
        req6    = 6'h00;
        q_ready = 1'b1;

        #3;
        chk("rst q", 32'(q), 32'h0);
        chk("rst q_ch", 32'(q_ch), 32'h0);
        chk("rst q_valid", 32'(q_valid), 32'h0);
        chk("rst gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        chk("rst hold q_valid", 32'(q_valid), 32'h0);
        rst_n = 1'b1;

        // Manual select of channel 3.
        mode = 1'b0; sel = 3'd3; req = 8'h08;
        cyc("man3", 3, 1'b1);

        // Manual select of a non-requesting channel: word drains, data held.
        sel = 3'd6;
        cyc("man6", -1, 1'b0);
        chk("man6 q_ch hold", 32'(q_ch), 32'd3);
        chk("man6 q hold", 32'(q), 32'(d[3]));

        // Manual ch4 then round-robin resumes after ch4.
        sel = 3'd4; req = 8'h10;
        cyc("man4", 4, 1'b1);
        mode = 1'b1; req = 8'h31;
        cyc("rr31 a", 5, 1'b1);
        cyc("rr31 b", 0, 1'b1);
        cyc("rr31 c", 4, 1'b1);

        // Park ptr at 7, then full round-robin sweep without bubbles.
        mode = 1'b0; sel = 3'd7; req = 8'h80;
        cyc("man7", 7, 1'b1);
        mode = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) cyc($sformatf("rrff %0d", i), i % 8, 1'b1);

        // Back-pressure holds ch2 for 5 cycles, then ch5 and ch2.
        req = 8'h24;
        cyc("rr24 first", 2, 1'b1);
        q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("stall %0d", i), -1, 1'b1);
            chk("stall q_ch", 32'(q_ch), 32'd2);
        end
        q_ready = 1'b1;
        cyc("rr24 next", 5, 1'b1);
        cyc("rr24 wrap", 2, 1'b1);

        // Single requester equal to ptr keeps winning.
        req = 8'h04;
        cyc("single a", 2, 1'b1);
        cyc("single b", 2, 1'b1);

        // Held word is immune to mode/sel/req changes.
        q_ready = 1'b0; mode = 1'b0; sel = 3'd1; req = 8'hFF;
        cyc("hold", -1, 1'b1);
        chk("hold q_ch", 32'(q_ch), 32'd2);
        chk("hold q", 32'(q), 32'(d[2]));

        // Asynchronous reset mid-word.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst q", 32'(q), 32'h0);
        chk("arst q_ch", 32'(q_ch), 32'h0);
        chk("arst q_valid", 32'(q_valid), 32'h0);
        chk("arst gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; q_ready = 1'b1; mode = 1'b1; req = 8'hC2;
        cyc("post rst a", 1, 1'b1);
        cyc("post rst b", 6, 1'b1);

        // Six-channel instance: sel=7 never granted.
        req = 8'h00; mode = 1'b0; sel = 3'd7; req6 = 6'h3F;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ch6 sel7 gnt", 32'(gnt6), 32'h0);
            @(posedge clk);
            #1;
            chk("ch6 sel7 q_valid", 32'(q_valid6), 32'h0);
        end

        // Six-channel round-robin wraps 5 -> 0.
        mode = 1'b1; req6 = 6'h21;
        @(negedge clk);
        chk("ch6 rr a", 32'(gnt6), 32'h01);
        @(posedge clk);
        #1;
        chk("ch6 rr a q", 32'(q6), 32'hC0);
        @(negedge clk);
        chk("ch6 rr b", 32'(gnt6), 32'h20);
        @(posedge clk);
        #1;
        chk("ch6 rr b q_ch", 32'(q_ch6), 32'd5);
        @(negedge clk);
        chk("ch6 rr wrap", 32'(gnt6), 32'h01);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
